// File: rtl/store_unit_pkg.sv
// rtl/store_unit_pkg.sv - shared types, size encodings and helpers for the store unit
//
// Contents:
//   DEFAULT_DEPTH  default number of store-buffer entries
//   size_e         store size encoding (byte/half/word/illegal)
//   drain_state_e  drain FSM states
//   entry_t        one formatted store-buffer entry (word address, lane data, byte enables)
//   align_ok       legality of a size/offset pair
//   format_store   turns a right-aligned store into a word-lane memory write
package store_unit_pkg;

    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    function automatic logic align_ok(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~off[0];
            SZ_WORD: return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Bytes above the store size are cleared before the lane shift so stale
    // upper bits of the source register never reach the bus.
    function automatic entry_t format_store(input logic [31:0] addr,
                                            input logic [31:0] data,
                                            input size_e       size);
        entry_t      e;
        logic [31:0] d;
        logic [3:0]  be;
        case (size)
            SZ_BYTE: begin d = {24'h0, data[7:0]};  be = 4'b0001; end
            SZ_HALF: begin d = {16'h0, data[15:0]}; be = 4'b0011; end
            default: begin d = data;                be = 4'b1111; end
        endcase
        e.addr = {addr[31:2], 2'b00};
        e.data = d << {addr[1:0], 3'b000};
        e.be   = be << addr[1:0];
        return e;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// rtl/store_unit_if.sv - memory write bus between the store unit and memory
//
// Signals:
//   mem_req    write request (store unit -> memory)
//   mem_addr   word-aligned write address
//   mem_wdata  write data in its byte lanes
//   mem_be     byte enables
//   mem_ack    memory accepted the current write (memory -> store unit)
interface store_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ack
    );

endinterface

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - store-buffer FIFO of formatted entries
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (flushes pointers and count)
//   push_i        enqueue push_data_i (ignored when full)
//   push_data_i   entry to enqueue
//   pop_i         drop the head entry (ignored when empty)
//   full_o        registered: count == DEPTH
//   empty_o       count == 0
//   last_o        count == 1
//   head_o        entry at the read pointer
//   next_o        entry behind the head, used to present back-to-back writes
module store_fifo
    import store_unit_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output logic   last_o,
    output entry_t head_o,
    output entry_t next_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            full_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & (cnt_q != '0);
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

    assign full_o  = full_q;
    assign empty_o = (cnt_q == '0);
    assign last_o  = (cnt_q == CW'(1));
    assign head_o  = mem_q[rd_q];
    assign next_o  = mem_q[rd_q + PW'(1)];

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - store unit: alignment check, lane formatting, store buffer and drain FSM
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   set_busy     store issue strobe (accepted only when busy=0)
//   store_addr   byte address of the store
//   store_data   right-aligned store data
//   store_size   00 byte, 01 half, 10 word, 11 illegal
//   busy         registered buffer-full flag
//   empty        buffer empty and no write outstanding
//   valid        one-cycle pulse per committed write
//   misalign     one-cycle pulse per rejected issue
//   mem          memory write bus (master side)
module store_unit
    import store_unit_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_busy,
    input  logic [31:0]        store_addr,
    input  logic [31:0]        store_data,
    input  logic [1:0]         store_size,
    output logic               busy,
    output logic               empty,
    output logic               valid,
    output logic               misalign,
    store_unit_if.master       mem
);

    drain_state_e state_q, state_d;
    entry_t       entry_q, entry_d;
    logic         valid_q, valid_d;
    logic         misalign_q, misalign_d;
    logic         pop;
    logic         legal;
    logic         issue_ok;
    logic         fifo_full, fifo_empty, fifo_last;
    entry_t       fifo_head, fifo_next, new_entry;

    assign legal      = align_ok(size_e'(store_size), store_addr[1:0]);
    assign new_entry  = format_store(store_addr, store_data, size_e'(store_size));
    // busy is the registered full flag, so a pop in this cycle cannot admit this cycle's issue.
    assign issue_ok   = set_busy & ~fifo_full & legal;
    assign misalign_d = set_busy & ~fifo_full & ~legal;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (issue_ok),
        .push_data_i (new_entry),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .last_o      (fifo_last),
        .head_o      (fifo_head),
        .next_o      (fifo_next)
    );

    // The presented write stays at the FIFO head until acknowledged, so it
    // still counts toward busy while outstanding.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        pop     = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_REQ;
                    entry_d = fifo_head;
                end
            end
            ST_REQ: begin
                if (mem.mem_ack) begin
                    pop     = 1'b1;
                    valid_d = 1'b1;
                    if (fifo_last) state_d = ST_IDLE;
                    else           entry_d = fifo_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            entry_q    <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign busy          = fifo_full;
    assign empty         = fifo_empty & (state_q == ST_IDLE);
    assign valid         = valid_q;
    assign misalign      = misalign_q;
    assign mem.mem_req   = (state_q == ST_REQ);
    assign mem.mem_addr  = entry_q.addr;
    assign mem.mem_wdata = entry_q.data;
    assign mem.mem_be    = entry_q.be;

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning store-buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port set_busy  input  1  store issue strobe; accepted only when busy=0.
REQ-005 SHALL have port store_addr  input  32  byte address of the store.
REQ-006 SHALL have port store_data  input  32  store data, right-aligned (bits [7:0] for byte).
REQ-007 SHALL have port store_size  input  2  size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port busy  output  1  buffer full; issue not accepted.
REQ-009 SHALL have port empty  output  1  buffer empty and no bus request outstanding.
REQ-010 SHALL have port valid  output  1  one-cycle pulse: one store committed to memory.
REQ-011 SHALL have port misalign  output  1  one-cycle pulse: issued store rejected.
REQ-012 SHALL have ports mem_req (output, 1), mem_addr (output, 32, word-aligned), mem_wdata (output, 32), mem_be (output, 4): memory write request.
REQ-013 SHALL have port mem_ack  input  1  memory accepted the current write.

Function
REQ-014 Issue SHALL be accepted iff set_busy=1, busy=0 and alignment is legal; the entry SHALL be enqueued at the next edge.
REQ-015 Legal alignment SHALL be: byte any address; half store_addr[0]=0; word store_addr[1:0]=00; size 11 is always illegal.
REQ-016 An illegal issue with busy=0 SHALL NOT enqueue and SHALL pulse misalign for exactly one cycle after the issue edge.
REQ-017 An issue while busy=1 SHALL be ignored: no enqueue, no misalign.
REQ-018 Enqueue SHALL store addr {store_addr[31:2],2'b00}, data shifted left by 8*store_addr[1:0], be = 0001/0011/1111 shifted left by store_addr[1:0].
REQ-019 busy SHALL be registered and equal (count==DEPTH); a pop in the same cycle SHALL NOT unblock that cycle's issue.
REQ-020 The drain FSM SHALL have states IDLE and REQ; mem_req=1 exactly in REQ.
REQ-021 IDLE->REQ SHALL occur when count>0; mem_addr/mem_wdata/mem_be SHALL be loaded from the head entry on that edge.
REQ-022 In REQ, mem_addr/mem_wdata/mem_be SHALL hold stable until mem_ack=1.
REQ-023 On mem_ack in REQ: head SHALL pop; valid SHALL pulse next cycle; if entries remain, SHALL stay in REQ presenting the next head with no bubble, otherwise go to IDLE.
REQ-024 Minimum latency SHALL be: issue edge N with buffer empty -> mem_req=1 from cycle N+2.
REQ-025 Simultaneous enqueue and pop SHALL leave count unchanged; entry order SHALL be strictly FIFO; pointers SHALL wrap modulo DEPTH.
REQ-026 mem_ack outside REQ SHALL be ignored.

Reset
REQ-027 rst=1 SHALL flush the buffer, set count=0, pointers=0, FSM=IDLE.
REQ-028 Reset values SHALL be: busy=0, empty=1, valid=0, misalign=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0.
REQ-029 Reset during REQ SHALL drop mem_req the next cycle; the pending write SHALL be discarded without a valid pulse.

Structure
REQ-030 Size encodings and the default DEPTH SHALL reside in the shared core package.
REQ-031 The buffer SHALL be a sub-module store_fifo (push, pop, full, empty, head data); alignment, formatting and drain FSM SHALL reside in store_unit.

Verification
REQ-032 Word store 0x0000_1004 / 0xDEADBEEF, mem_ack after 2 cycles -> mem_addr=0x1004, mem_be=1111, mem_wdata=0xDEADBEEF, one valid pulse, empty=1 after.
REQ-033 Byte store 0x1003 / 0x000000AB -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xAB000000.
REQ-034 Half store 0x1001 and word store 0x1002 -> misalign pulse each, no mem_req, empty stays 1.
REQ-035 Five back-to-back issues, mem_ack held 0 -> first four accepted, busy=1, fifth ignored; then mem_ack=1 continuously -> four commits in issue order on consecutive cycles, no bubble.
REQ-036 Issue at full with mem_ack in the same cycle -> issue dropped, count 4->3.
REQ-037 rst asserted during REQ with 3 entries -> mem_req=0 next cycle, no valid pulse, empty=1, busy=0.
